// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: op codes, FSM states, width floor.
package alu_pkg;

  localparam int MIN_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTB = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_RSUB = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIVU = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU. The master side issues
// operands and consumes results; the slave side is the ALU itself.
interface iter_alu_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, remainder, zero, carry, ovf, div0
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, remainder, zero, carry, ovf, div0
  );
endinterface

// File: rtl/iter_muldiv.sv
// Shared iterative engine: WIDTH-step shift-add multiply and, when
// ITER_ALU_DIV_EN is defined, WIDTH-step restoring unsigned divide.
// lo/hi present the value the registers take on the step where done is
// high: {hi,lo} = product, or hi = remainder, lo = quotient.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ITER_ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_sreg;
  logic [WIDTH:0]   sum;
`ifdef ITER_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;
  logic             q_bit;
`endif

  // Next value of {acc,sreg} for one multiply or divide step.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sum       = sreg[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    step_acc  = sum[WIDTH:1];
    step_sreg = {sum[0], sreg[WIDTH-1:1]};
`ifdef ITER_ALU_DIV_EN
    shifted   = {acc, sreg[WIDTH-1]};
    q_bit     = (shifted >= {1'b0, opnd});
    if (div_q) begin
      step_acc  = q_bit ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      step_sreg = {sreg[WIDTH-2:0], q_bit};
    end
`endif
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign lo   = step_sreg;
  assign hi   = step_acc;

  // Load operands on start, then advance one step per cycle until done.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so nothing in the block is ever X after reset.
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sreg  <= '0;
      opnd  <= '0;
`ifdef ITER_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      sreg  <= a;
      opnd  <= b;
`ifdef ITER_ALU_DIV_EN
      div_q <= is_div;
`endif
    end else if (busy) begin
      acc  <= step_acc;
      sreg <= step_sreg;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU with valid/ready on both sides. Logic/add/sub ops finish
// in one cycle; MUL (and DIVU when ITER_ALU_DIV_EN is defined) run WIDTH
// steps in iter_muldiv. Without ITER_ALU_DIV_EN, DIVU returns zero in one
// cycle and remainder/div0 are tied low. WIDTH must be at least MIN_WIDTH.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  iter_alu_if.slave bus
);

  alu_state_e       state, next_state;
  alu_op_e          op_in;
  logic             accept;
  logic             long_op;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] f_res;
  logic             f_carry, f_ovf;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, carry_q, ovf_q;
`ifdef ITER_ALU_DIV_EN
  logic [WIDTH-1:0] f_rem, rem_q;
  logic             f_div0, div0_q, div_q;
`endif

  assign op_in = alu_op_e'(bus.op);

`ifdef ITER_ALU_DIV_EN
  assign long_op = (op_in == OP_MUL) || ((op_in == OP_DIVU) && (bus.b != '0));
`else
  assign long_op = (op_in == OP_MUL);
`endif

  // Single-cycle result and flags straight from the incoming operands.
  always_comb begin
    wide    = '0;
    f_res   = '0;
    f_carry = 1'b0;
    f_ovf   = 1'b0;
`ifdef ITER_ALU_DIV_EN
    f_rem   = '0;
    f_div0  = 1'b0;
`endif
    case (op_in)
      OP_AND:  f_res = bus.a & bus.b;
      OP_OR:   f_res = bus.a | bus.b;
      OP_NOTB: f_res = ~bus.b;
      OP_ADD: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        f_res   = wide[WIDTH-1:0];
        f_carry = wide[WIDTH];
        f_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (f_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b};
        f_res   = wide[WIDTH-1:0];
        f_carry = wide[WIDTH];
        f_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (f_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_RSUB: begin
        wide    = {1'b0, bus.b} - {1'b0, bus.a};
        f_res   = wide[WIDTH-1:0];
        f_carry = wide[WIDTH];
        f_ovf   = (bus.b[WIDTH-1] != bus.a[WIDTH-1]) && (f_res[WIDTH-1] != bus.b[WIDTH-1]);
      end
`ifdef ITER_ALU_DIV_EN
      OP_DIVU: begin
        // Only reaches the output registers when b == 0.
        f_res  = '1;
        f_rem  = bus.a;
        f_div0 = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state and accept decision.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          next_state = long_op ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (md_done) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept     = 1'b1;
            next_state = long_op ? ST_BUSY : ST_DONE;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign md_start = accept && long_op;

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
`ifdef ITER_ALU_DIV_EN
    .is_div (op_in == OP_DIVU),
`endif
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Result/flag registers: load on a single-cycle accept or on engine done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      rem_q   <= '0;
      div0_q  <= 1'b0;
      div_q   <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ITER_ALU_DIV_EN
      div_q <= (op_in == OP_DIVU);
`endif
      if (!long_op) begin
        res_q   <= f_res;
        zero_q  <= (f_res == '0);
        carry_q <= f_carry;
        ovf_q   <= f_ovf;
`ifdef ITER_ALU_DIV_EN
        rem_q   <= f_rem;
        div0_q  <= f_div0;
`endif
      end
    end else if (md_done) begin
      res_q   <= md_lo;
      zero_q  <= (md_lo == '0);
      carry_q <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      ovf_q   <= !div_q && (md_hi != '0);
      rem_q   <= div_q ? md_hi : '0;
      div0_q  <= 1'b0;
`else
      ovf_q   <= (md_hi != '0);
`endif
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
`ifdef ITER_ALU_DIV_EN
  assign bus.remainder = rem_q;
  assign bus.div0      = div0_q;
`else
  assign bus.remainder = '0;
  assign bus.div0      = 1'b0;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=16): directed cases, backpressure,
// mid-operation reset and random ops against an arithmetic reference model.
module tb_iter_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(W)) bus ();

  iter_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         div0;
    int           lat;
  } exp_t;

  // Reference model built from the arithmetic definitions of each op.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    exp_t   e;
    longint ua, ub, sa, sb, full, smax, smin, lim;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    lim  = longint'(1) << W;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    e.res = '0; e.rem = '0; e.carry = 1'b0; e.ovf = 1'b0; e.div0 = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = ~b;
      3'd3: begin
        full    = ua + ub;
        e.res   = W'(full);
        e.carry = (full >= lim);
        e.ovf   = (sa + sb > smax) || (sa + sb < smin);
      end
      3'd4: begin
        e.res   = W'(ua - ub);
        e.carry = (ua < ub);
        e.ovf   = (sa - sb > smax) || (sa - sb < smin);
      end
      3'd5: begin
        e.res   = W'(ub - ua);
        e.carry = (ub < ua);
        e.ovf   = (sb - sa > smax) || (sb - sa < smin);
      end
      3'd6: begin
        full  = ua * ub;
        e.res = W'(full);
        e.ovf = (full >= lim);
        e.lat = W + 1;
      end
      default: begin
`ifdef ITER_ALU_DIV_EN
        if (ub == 0) begin
          e.res  = '1;
          e.rem  = a;
          e.div0 = 1'b1;
        end else begin
          e.res = W'(ua / ub);
          e.rem = W'(ua % ub);
          e.lat = W + 1;
        end
`endif
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, ".result"}, 64'(bus.result), 64'(e.res));
    check({tag, ".rem"}, 64'(bus.remainder), 64'(e.rem));
    check({tag, ".zero"}, 64'(bus.zero), 64'(e.zero));
    check({tag, ".carry"}, 64'(bus.carry), 64'(e.carry));
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(e.ovf));
    check({tag, ".div0"}, 64'(bus.div0), 64'(e.div0));
  endtask

  // Issue one op with out_ready high, measure latency, check everything.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op);
    exp_t e;
    int   n;
    int   lat;
    int   busy_ready;
    bit   seen;
    e = model(a, b, op);
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy_ready = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (bus.in_ready !== 1'b0) busy_ready++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(e.lat));
    check({tag, ".busy_in_ready"}, 64'(busy_ready), 64'(0));
    check_outputs(tag, e);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e, e2;
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #12;
    check("reset.out_valid", 64'(bus.out_valid), 64'(0));
    check("reset.in_ready", 64'(bus.in_ready), 64'(1));
    check("reset.result", 64'(bus.result), 64'(0));
    check("reset.flags", 64'({bus.zero, bus.carry, bus.ovf, bus.div0}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("add_ovf", 16'h7FFF, 16'h0001, OP_ADD);
    check("add_ovf.const", 64'(bus.result), 64'(16'h8000));
    run_op("sub_eq", 16'd5, 16'd5, OP_SUB);
    run_op("rsub", 16'd5, 16'd3, OP_RSUB);
    check("rsub.const", 64'(bus.result), 64'(16'hFFFE));
    run_op("notb", 16'h1234, 16'h00FF, OP_NOTB);
    run_op("mul300", 16'd300, 16'd300, OP_MUL);
    check("mul300.const", 64'(bus.result), 64'(16'h5F90));
    run_op("mul_max", 16'hFFFF, 16'hFFFF, OP_MUL);
    run_op("add_carry", 16'hFFFF, 16'h0001, OP_ADD);
    run_op("div100_7", 16'd100, 16'd7, OP_DIVU);
    run_op("div9_0", 16'd9, 16'd0, OP_DIVU);
    run_op("div_max_1", 16'hFFFF, 16'd1, OP_DIVU);
    run_op("and", 16'hAAAA, 16'h0FF0, OP_AND);
    run_op("or", 16'hA000, 16'h000A, OP_OR);

    // Backpressure: result held for 5 cycles, then re-accept on release.
    e = model(16'h1234, 16'h4321, OP_ADD);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h4321;
    bus.op        = OP_ADD;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_outputs("bp.first", e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outputs("bp.hold", e);
      check("bp.in_ready_low", 64'(bus.in_ready), 64'(0));
    end
    e2 = model(16'h0F00, 16'h00F0, OP_OR);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0F00;
    bus.b         = 16'h00F0;
    bus.op        = OP_OR;
    #1;
    check("bp.in_ready_release", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_outputs("bp.next", e2);

    // Reset in the middle of a MUL.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'd300;
    bus.b        = 16'd300;
    bus.op       = OP_MUL;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", 64'(bus.out_valid), 64'(0));
    check("mrst.in_ready", 64'(bus.in_ready), 64'(1));
    check("mrst.result", 64'(bus.result), 64'(0));
    check("mrst.rem", 64'(bus.remainder), 64'(0));
    check("mrst.flags", 64'({bus.zero, bus.carry, bus.ovf, bus.div0}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_and", 16'hF0F0, 16'h0FF0, OP_AND);
    check("post_rst_and.const", 64'(bus.result), 64'(16'h00F0));

    // Random ops.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) rb = '0;
      else if ($urandom_range(3) == 0) rb = W'($urandom_range(20));
      run_op($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
